spi_master: RTL and testbench

Single-clock SPI master that issues command frames to the SPI slave and, for read-data commands, captures the returned byte from MISO. It sits directly upstream of the SPI slave / RAM wrapper, driving `MOSI` and `SS_n` and consuming `MISO`. Its command-side valid/ready port lets a controller or testbench sequencer issue RAM write-address, write-data, read-address and read-data transactions without bit-level timing.

---
 rtl/spi_master_pkg.sv | 30 +++
 rtl/spi_shift_reg.sv | 39 +++
 rtl/spi_master.sv | 163 ++++++++++++++++
 tb/tb_spi_master.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_pkg.sv
// Shared types and constants for the SPI command master.
package spi_master_pkg;

  // Frame is {cmd[1:0], data[7:0]}
  localparam int FRAME_W = 10;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEL     = 3'd1,
    SHIFT   = 3'd2,
    WAIT    = 3'd3,
    CAPTURE = 3'd4,
    DONE    = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_e;

  // Slave select is driven low in every state that belongs to an open frame.
  function automatic logic ss_active(input state_e s);
    return (s == SEL) || (s == SHIFT) || (s == WAIT) || (s == CAPTURE);
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load shift register, MSB-first serial out and LSB serial in.
// The same register carries the outgoing frame and then collects the
// returned read byte, since both are never live at the same time.
module spi_shift_reg
  import spi_master_pkg::*;
#(
  parameter int W     = FRAME_W,
  parameter int OUT_W = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [W-1:0]     load_data,
  input  logic             shift,
  input  logic             sin,
  output logic             sout,
  output logic [OUT_W-1:0] peek
);

  logic [W-1:0] q_reg;

  // Load has priority over shift; zeros fill from the bottom while sending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg <= '0;
    end else if (load) begin
      q_reg <= load_data;
    end else if (shift) begin
      q_reg <= {q_reg[W-2:0], sin};
    end
  end

  assign sout = q_reg[W-1];

  // Low OUT_W bits as they will be after the current shift; lets the master
  // register the completed byte on the same edge that samples its last bit.
  assign peek = {q_reg[OUT_W-2:0], sin};

endmodule

// File: rtl/spi_master.sv
// SPI command master: sends {cmd, data} MSB first after a one-cycle select
// bit, and for read-data commands waits TURNAROUND cycles then samples an
// 8-bit response from MISO. One SPI bit per system clock.
module spi_master
  import spi_master_pkg::*;
#(
  // Idle cycles between last MOSI bit and first MISO sample; 1..15.
  parameter int TURNAROUND = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_cmd,
  input  logic [DATA_W-1:0] req_data,
  output logic              MOSI,
  output logic              SS_n,
  input  logic              MISO,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy
);

  // Counter reload values; each phase counts down to zero then exits.
  localparam logic [CNT_W-1:0] SHIFT_LOAD = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(TURNAROUND - 1);
  localparam logic [CNT_W-1:0] CAPT_LOAD  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  cmd_e              cmd_reg, cmd_next;
  logic              mosi_reg, mosi_next;
  logic              ss_n_reg;
  logic              rsp_valid_reg;
  logic [DATA_W-1:0] rsp_data_reg, rsp_data_next;

  logic              sr_load;
  logic              sr_shift;
  logic              sr_sin;
  logic              sr_sout;
  logic [DATA_W-1:0] sr_peek;

  spi_shift_reg #(
    .W     (FRAME_W),
    .OUT_W (DATA_W)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .load      (sr_load),
    .load_data ({req_cmd, req_data}),
    .shift     (sr_shift),
    .sin       (sr_sin),
    .sout      (sr_sout),
    .peek      (sr_peek)
  );

  // Next-state, counter and next-output decode. Outputs are computed for
  // the state being entered so that the registered pins line up with it.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    cmd_next      = cmd_reg;
    mosi_next     = 1'b0;
    rsp_data_next = rsp_data_reg;
    sr_load       = 1'b0;
    sr_shift      = 1'b0;
    sr_sin        = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (req_valid) begin
          state_next = SEL;
          cmd_next   = cmd_e'(req_cmd);
          sr_load    = 1'b1;
          // Select cycle carries the read/write bit ahead of the frame.
          mosi_next  = req_cmd[1];
        end
      end

      SEL: begin
        state_next = SHIFT;
        cnt_next   = SHIFT_LOAD;
        mosi_next  = sr_sout;
        sr_shift   = 1'b1;
      end

      SHIFT: begin
        if (cnt_reg == '0) begin
          if (cmd_reg == RD_DATA) begin
            state_next = WAIT;
            cnt_next   = WAIT_LOAD;
          end else begin
            state_next = DONE;
          end
        end else begin
          cnt_next  = cnt_reg - CNT_ONE;
          mosi_next = sr_sout;
          sr_shift  = 1'b1;
        end
      end

      WAIT: begin
        if (cnt_reg == '0) begin
          state_next = CAPTURE;
          cnt_next   = CAPT_LOAD;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end

      CAPTURE: begin
        // The register was left all-zero by the frame shift, so after eight
        // shifts its low byte is exactly the received byte.
        sr_shift = 1'b1;
        sr_sin   = MISO;
        if (cnt_reg == '0) begin
          state_next    = DONE;
          rsp_data_next = sr_peek;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, counter and registered pins; async reset aborts any frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      cmd_reg       <= WR_ADDR;
      mosi_reg      <= 1'b0;
      ss_n_reg      <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      cmd_reg       <= cmd_next;
      mosi_reg      <= mosi_next;
      ss_n_reg      <= ~ss_active(state_next);
      rsp_valid_reg <= (state_next == DONE);
      rsp_data_reg  <= rsp_data_next;
    end
  end

  assign MOSI      = mosi_reg;
  assign SS_n      = ss_n_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign req_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: two instances (TURNAROUND 2 and 15).
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_cmd;
  logic [7:0] req_data;
  logic       MOSI;
  logic       SS_n;
  logic       MISO;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;

  logic       b_valid;
  logic       b_ready;
  logic       b_mosi;
  logic       b_ss_n;
  logic       b_rsp_valid;
  logic [7:0] b_rsp_data;
  logic       b_busy;
  logic       b_miso = 1'b1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spi_master #(.TURNAROUND(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_data(req_data), .MOSI(MOSI), .SS_n(SS_n),
    .MISO(MISO), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  spi_master #(.TURNAROUND(15)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready),
    .req_cmd(req_cmd), .req_data(req_data), .MOSI(b_mosi), .SS_n(b_ss_n),
    .MISO(b_miso), .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one frame on dut and follow it until SS_n rises (bounded).
  task automatic do_frame(input logic [1:0] cmd, input logic [7:0] data,
                          input logic [7:0] late_data, input logic [7:0] miso_byte,
                          input int first_cap, output int low_cnt,
                          output logic [33:0] mosi_bits, output logic rsp_seen,
                          output logic [7:0] rsp_byte);
    int cyc;
    @(negedge clk);
    req_valid = 1'b1; req_cmd = cmd; req_data = data;
    @(negedge clk);
    req_valid = 1'b0; req_data = late_data;
    low_cnt = 0; mosi_bits = '0; cyc = 1;
    while (SS_n == 1'b0 && cyc < 45) begin
      mosi_bits = {mosi_bits[32:0], MOSI};
      low_cnt++;
      if (cyc >= first_cap && cyc < first_cap + 8) MISO = miso_byte[7 - (cyc - first_cap)];
      else MISO = 1'b0;
      @(negedge clk);
      cyc++;
    end
    MISO = 1'b0;
    rsp_seen = rsp_valid;
    rsp_byte = rsp_data;
  endtask

  int          low_cnt;
  logic [33:0] mosi_bits;
  logic        rsp_seen;
  logic [7:0]  rsp_byte;
  logic [30:1] ss_v, rdy_v, rv_v, mo_v;
  logic [10:0] w1, w2;
  int          first_rdy, gap, pulses;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_cmd = 2'b00; req_data = 8'h00;
    MISO = 1'b0; b_valid = 1'b0;
    #12;
    check("reset SS_n", SS_n, 1'b1);
    check("reset MOSI", MOSI, 1'b0);
    check("reset req_ready", req_ready, 1'b1);
    check("reset rsp_valid", rsp_valid, 1'b0);
    check("reset rsp_data", rsp_data, 8'h00);
    check("reset busy", busy, 1'b0);
    @(negedge clk); rst = 1'b0;

    // WR_ADDR A5
    do_frame(2'b00, 8'hA5, 8'hA5, 8'h00, 100, low_cnt, mosi_bits, rsp_seen, rsp_byte);
    check("wra ss_low", low_cnt, 11);
    check("wra mosi", mosi_bits[10:0], 11'h0A5);
    check("wra rsp_valid", rsp_seen, 1'b1);
    check("wra rsp_data", rsp_byte, 8'h00);
    $display("frame WR_ADDR A5: ss_low=%0d mosi=%03h rsp_valid=%0b", low_cnt, mosi_bits[10:0], rsp_seen);

    // RD_DATA, slave returns 3C from cycle 14
    do_frame(2'b11, 8'h00, 8'h00, 8'h3C, 14, low_cnt, mosi_bits, rsp_seen, rsp_byte);
    check("rdd ss_low", low_cnt, 21);
    check("rdd mosi", mosi_bits[20:10], 11'h700);
    check("rdd rsp_valid", rsp_seen, 1'b1);
    check("rdd rsp_data", rsp_byte, 8'h3C);
    $display("frame RD_DATA T=2: ss_low=%0d rsp_data=%02h", low_cnt, rsp_byte);

    // Back-to-back WR_DATA 11 then RD_ADDR 22 with req_valid held high
    @(negedge clk);
    req_valid = 1'b1; req_cmd = 2'b01; req_data = 8'h11;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) begin req_cmd = 2'b10; req_data = 8'h22; end
      ss_v[c] = SS_n; rdy_v[c] = req_ready; rv_v[c] = rsp_valid; mo_v[c] = MOSI;
      if (c == 14) req_valid = 1'b0;
    end
    first_rdy = 0; gap = 0; pulses = 0; w1 = '0; w2 = '0;
    for (int c = 30; c >= 1; c--) if (rdy_v[c]) first_rdy = c;
    for (int c = 1; c <= 24; c++) if (ss_v[c]) gap++;
    for (int c = 1; c <= 30; c++) if (rv_v[c]) pulses++;
    for (int c = 1; c <= 11; c++) w1 = {w1[9:0], mo_v[c]};
    for (int c = 14; c <= 24; c++) w2 = {w2[9:0], mo_v[c]};
    check("b2b first ready", first_rdy, 13);
    check("b2b ss high gap", gap, 2);
    check("b2b frame1 mosi", w1, 11'h111);
    check("b2b frame2 mosi", w2, 11'h622);
    check("b2b rsp pulse1", rv_v[12], 1'b1);
    check("b2b rsp pulse2", rv_v[25], 1'b1);
    check("b2b pulse count", pulses, 2);
    check("b2b rsp_data kept", rsp_data, 8'h3C);
    $display("back-to-back: first_ready=%0d gap=%0d mosi1=%03h mosi2=%03h", first_rdy, gap, w1, w2);

    // req_data changes right after accept: frame must carry F0
    do_frame(2'b01, 8'hF0, 8'h0F, 8'h00, 100, low_cnt, mosi_bits, rsp_seen, rsp_byte);
    check("latch ss_low", low_cnt, 11);
    check("latch mosi", mosi_bits[10:0], 11'h1F0);
    check("latch rsp_valid", rsp_seen, 1'b1);
    $display("frame WR_DATA F0 (late 0F): mosi=%03h", mosi_bits[10:0]);

    // rst together with req_valid: no accept
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b1; req_cmd = 2'b00; req_data = 8'h55;
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    check("rst+valid busy", busy, 1'b0);
    check("rst+valid SS_n", SS_n, 1'b1);
    $display("rst with req_valid: busy=%0b SS_n=%0b", busy, SS_n);

    // rst during SHIFT bit 5 of WR_DATA
    @(negedge clk);
    req_valid = 1'b1; req_cmd = 2'b01; req_data = 8'h5A;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("abort pre busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("abort SS_n", SS_n, 1'b1);
    check("abort req_ready", req_ready, 1'b1);
    check("abort MOSI", MOSI, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      if (rsp_valid) pulses++;
      @(negedge clk);
    end
    check("abort no rsp", pulses, 0);
    check("abort rsp_data", rsp_data, 8'h00);
    do_frame(2'b00, 8'h0F, 8'h0F, 8'h00, 100, low_cnt, mosi_bits, rsp_seen, rsp_byte);
    check("post ss_low", low_cnt, 11);
    check("post mosi", mosi_bits[10:0], 11'h00F);
    check("post rsp_valid", rsp_seen, 1'b1);
    $display("abort then WR_ADDR 0F: pulses=%0d mosi=%03h", pulses, mosi_bits[10:0]);

    // TURNAROUND=15 instance, MISO tied high
    @(negedge clk);
    b_valid = 1'b1; req_cmd = 2'b11; req_data = 8'h00;
    @(negedge clk);
    b_valid = 1'b0;
    check("t15 ready", b_ready, 1'b0);
    check("t15 busy", b_busy, 1'b1);
    check("t15 sel mosi", b_mosi, 1'b1);
    low_cnt = 0;
    while (b_ss_n == 1'b0 && low_cnt < 50) begin
      low_cnt++;
      @(negedge clk);
    end
    check("t15 ss_low", low_cnt, 34);
    check("t15 rsp_valid", b_rsp_valid, 1'b1);
    check("t15 rsp_data", b_rsp_data, 8'hFF);
    $display("frame RD_DATA T=15: ss_low=%0d rsp_data=%02h", low_cnt, b_rsp_data);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
